// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI flash read arbiter.
package spi_arb_pkg;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef enum logic {OWNER_INSTR, OWNER_DATA} owner_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/spi_arb_timer.sv
// BUSY-cycle watchdog: counts enabled cycles and flags the last allowed one.
module spi_arb_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Expires during the TIMEOUT_CYCLES-th enabled cycle so the abort lines up with a done.
  assign expired = enable && (r_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash read engine between instruction and data buses.
// Optional SPI_ARB_ROUND_ROBIN_EN: alternate winner on conflicts instead of data priority.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int FLASH_ADDR_WIDTH = 24,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        instr_req_i,
  input  logic [ADDR_WIDTH-1:0]       instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  input  logic                        data_req_i,
  input  logic [ADDR_WIDTH-1:0]       data_addr_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic [31:0]                 data_rdata_o,
  output logic                        flash_strobe_o,
  output logic [FLASH_ADDR_WIDTH-1:0] flash_addr_o,
  input  logic                        flash_done_i,
  input  logic [31:0]                 flash_rdata_i,
  input  logic                        flash_initialized_i,
  output logic                        timeout_o
);

  state_e                      r_state;
  owner_e                      r_owner;
  logic [FLASH_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]                 r_rdata;
  logic                        r_strobe;
  logic                        r_instr_rvalid;
  logic                        r_data_rvalid;
  logic                        r_timeout;

  logic                        w_can_grant;
  logic                        w_data_wins;
  logic                        w_expired;
  logic [ADDR_WIDTH-1:0]       w_sel_addr;
  logic                        w_unused;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  owner_e r_last;
  assign w_data_wins = data_req_i && (!instr_req_i || (r_last == OWNER_INSTR));
`else
  assign w_data_wins = data_req_i;
`endif

  // Grant sees only req, state and init; reset also forces it low.
  assign w_can_grant = rst_ni && (r_state == IDLE) && flash_initialized_i;
  assign data_gnt_o  = w_can_grant && w_data_wins;
  assign instr_gnt_o = w_can_grant && instr_req_i && !w_data_wins;
  assign w_sel_addr  = data_gnt_o ? data_addr_i : instr_addr_i;

  assign w_unused = ^{instr_addr_i[ADDR_WIDTH-1:FLASH_ADDR_WIDTH], instr_addr_i[1:0],
                      data_addr_i[ADDR_WIDTH-1:FLASH_ADDR_WIDTH], data_addr_i[1:0]};

  spi_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (r_state == IDLE),
    .enable ((r_state == BUSY) && !flash_done_i),
    .expired(w_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_owner        <= OWNER_INSTR;
      r_addr         <= '0;
      r_rdata        <= '0;
      r_strobe       <= 1'b0;
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      r_timeout      <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      r_last         <= OWNER_DATA;
`endif
    end else begin
      r_strobe       <= 1'b0;
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (data_gnt_o || instr_gnt_o) begin
            r_state  <= BUSY;
            r_owner  <= data_gnt_o ? OWNER_DATA : OWNER_INSTR;
            r_addr   <= {w_sel_addr[FLASH_ADDR_WIDTH-1:2], 2'b00};
            r_strobe <= 1'b1;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            r_last   <= data_gnt_o ? OWNER_DATA : OWNER_INSTR;
`endif
          end
        end
        BUSY: begin
          // A done in the expiry cycle still delivers real data.
          if (flash_done_i || w_expired) begin
            r_state        <= IDLE;
            r_rdata        <= flash_done_i ? flash_rdata_i : TIMEOUT_DATA;
            r_instr_rvalid <= (r_owner == OWNER_INSTR);
            r_data_rvalid  <= (r_owner == OWNER_DATA);
            if (!flash_done_i) begin
              r_timeout <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flash_strobe_o = r_strobe;
  assign flash_addr_o   = r_addr;
  assign instr_rvalid_o = r_instr_rvalid;
  assign data_rvalid_o  = r_data_rvalid;
  assign instr_rdata_o  = r_instr_rvalid ? r_rdata : 32'h0;
  assign data_rdata_o   = r_data_rvalid ? r_rdata : 32'h0;
  assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: directed scenarios plus random traffic vs a cycle-count model.
module tb_spi_flash_arbiter;
  import spi_arb_pkg::*;

  localparam int AW  = 32;
  localparam int FAW = 24;
  localparam int TO  = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            instr_req_i = 1'b0, data_req_i = 1'b0;
  logic [AW-1:0]   instr_addr_i = '0, data_addr_i = '0;
  logic            instr_gnt_o, data_gnt_o;
  logic            instr_rvalid_o, data_rvalid_o;
  logic [31:0]     instr_rdata_o, data_rdata_o;
  logic            flash_strobe_o;
  logic [FAW-1:0]  flash_addr_o;
  logic            flash_done_i = 1'b0;
  logic [31:0]     flash_rdata_i = '0;
  logic            flash_initialized_i = 1'b0;
  logic            timeout_o;

  spi_flash_arbiter #(
    .ADDR_WIDTH(AW), .FLASH_ADDR_WIDTH(FAW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .flash_strobe_o(flash_strobe_o), .flash_addr_o(flash_addr_o),
    .flash_done_i(flash_done_i), .flash_rdata_i(flash_rdata_i),
    .flash_initialized_i(flash_initialized_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transaction is described by its grant cycle; everything else is arithmetic.
  bit          m_busy = 0;
  owner_e      m_owner = OWNER_INSTR;
  owner_e      m_last = OWNER_DATA;
  logic [23:0] m_addr = '0;
  int          m_gcyc = 0;
  bit          m_to = 0;
  bit          e_rvi = 0, e_rvd = 0;
  logic [31:0] e_rd = '0;

  always @(negedge clk_i) begin
    bit          egi, egd, ests;
    logic [31:0] eri, erd, a;
    if (!rst_ni) begin
      chk("rst_instr_gnt", instr_gnt_o, 0);
      chk("rst_data_gnt", data_gnt_o, 0);
      chk("rst_strobe", flash_strobe_o, 0);
      chk("rst_addr", flash_addr_o, 0);
      chk("rst_instr_rvalid", instr_rvalid_o, 0);
      chk("rst_data_rvalid", data_rvalid_o, 0);
      chk("rst_instr_rdata", instr_rdata_o, 0);
      chk("rst_data_rdata", data_rdata_o, 0);
      chk("rst_timeout", timeout_o, 0);
      m_busy = 0; m_last = OWNER_DATA; m_addr = '0; m_to = 0;
      e_rvi = 0; e_rvd = 0; e_rd = '0;
    end else begin
      ests = m_busy && (cyc == m_gcyc + 1);
      egi = 0; egd = 0;
      if (!m_busy && flash_initialized_i) begin
        if (data_req_i && instr_req_i) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
          if (m_last == OWNER_DATA) egi = 1; else egd = 1;
`else
          egd = 1;
`endif
        end else begin
          egd = data_req_i;
          egi = instr_req_i;
        end
      end
      eri = e_rvi ? e_rd : 32'h0;
      erd = e_rvd ? e_rd : 32'h0;
      chk("instr_gnt", instr_gnt_o, egi);
      chk("data_gnt", data_gnt_o, egd);
      chk("strobe", flash_strobe_o, ests);
      chk("flash_addr", flash_addr_o, m_addr);
      chk("instr_rvalid", instr_rvalid_o, e_rvi);
      chk("data_rvalid", data_rvalid_o, e_rvd);
      chk("instr_rdata", instr_rdata_o, eri);
      chk("data_rdata", data_rdata_o, erd);
      chk("timeout", timeout_o, m_to);
      e_rvi = 0; e_rvd = 0;
      if (m_busy && (flash_done_i || (cyc - m_gcyc == TO))) begin
        e_rd  = flash_done_i ? flash_rdata_i : 32'h0;
        if (!flash_done_i) m_to = 1;
        e_rvi = (m_owner == OWNER_INSTR);
        e_rvd = (m_owner == OWNER_DATA);
        m_busy = 0;
        $display("txn %s addr=%06h rdata=%08h busy=%0d%s",
                 (m_owner == OWNER_DATA) ? "data " : "instr", m_addr, e_rd,
                 cyc - m_gcyc, flash_done_i ? "" : " timeout");
      end
      if (egi || egd) begin
        a = egd ? data_addr_i : instr_addr_i;
        m_busy  = 1;
        m_gcyc  = cyc;
        m_owner = egd ? OWNER_DATA : OWNER_INSTR;
        m_last  = m_owner;
        m_addr  = {a[23:2], 2'b00};
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  owner_e first;
  bit gi, gd;

  initial begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
    first = OWNER_INSTR;
`else
    first = OWNER_DATA;
`endif
    repeat (3) tick();
    chk("reset_timeout_lit", timeout_o, 0);
    rst_ni = 1; flash_initialized_i = 1;
    tick();

    // Single data read, done at D=5.
    data_req_i = 1; data_addr_i = 32'h0220_0010; #1;
    chk("t1_gnt", data_gnt_o, 1);
    tick(); data_req_i = 0;
    chk("t1_strobe", flash_strobe_o, 1);
    chk("t1_addr", flash_addr_o, 24'h200010);
    repeat (3) tick();
    chk("t1_strobe_low", flash_strobe_o, 0);
    tick(); flash_done_i = 1; flash_rdata_i = 32'hCAFE_F00D;
    chk("t1_no_early_rvalid", data_rvalid_o, 0);
    tick(); flash_done_i = 0;
    chk("t1_rvalid", data_rvalid_o, 1);
    chk("t1_rdata", data_rdata_o, 32'hCAFE_F00D);
    chk("t1_instr_quiet", instr_rvalid_o, 0);

    // Simultaneous requests.
    tick();
    data_req_i = 1; data_addr_i = 32'h0220_0000;
    instr_req_i = 1; instr_addr_i = 32'h0220_0004; #1;
    chk("t2_data_gnt", data_gnt_o, first == OWNER_DATA);
    chk("t2_instr_gnt", instr_gnt_o, first == OWNER_INSTR);
    tick();
    if (first == OWNER_DATA) data_req_i = 0; else instr_req_i = 0;
    chk("t2_addr1", flash_addr_o, (first == OWNER_DATA) ? 24'h200000 : 24'h200004);
    tick(); flash_done_i = 1; flash_rdata_i = 32'h1111_1111;
    tick(); flash_done_i = 0; #1;
    chk("t2_rvalid1", (first == OWNER_DATA) ? data_rvalid_o : instr_rvalid_o, 1);
    chk("t2_gnt2", (first == OWNER_DATA) ? instr_gnt_o : data_gnt_o, 1);
    tick(); data_req_i = 0; instr_req_i = 0;
    flash_done_i = 1; flash_rdata_i = 32'h2222_2222;
    chk("t2_addr2", flash_addr_o, (first == OWNER_DATA) ? 24'h200004 : 24'h200000);
    tick(); flash_done_i = 0;
    chk("t2_rdata2", (first == OWNER_DATA) ? instr_rdata_o : data_rdata_o, 32'h2222_2222);

    // Flash not initialised: no grants for 20 cycles.
    tick(); flash_initialized_i = 0;
    data_req_i = 1; data_addr_i = 32'h0220_0100;
    instr_req_i = 1; instr_addr_i = 32'h0220_0200;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t3_no_gnt", {30'b0, instr_gnt_o, data_gnt_o}, 0);
      chk("t3_no_strobe", flash_strobe_o, 0);
      tick();
    end
    flash_initialized_i = 1; #1;
    chk("t3_gnt_on_init", (first == OWNER_DATA) ? data_gnt_o : instr_gnt_o, 1);
    tick();
    if (first == OWNER_DATA) data_req_i = 0; else instr_req_i = 0;
    flash_done_i = 1; flash_rdata_i = 32'h5555_0001;
    tick(); flash_done_i = 0;
    tick(); data_req_i = 0; instr_req_i = 0;
    flash_done_i = 1; flash_rdata_i = 32'h5555_0002;
    tick(); flash_done_i = 0;

    // Done withheld: timeout after TO BUSY cycles.
    tick();
    instr_req_i = 1; instr_addr_i = 32'h0220_0100; #1;
    chk("t4_gnt", instr_gnt_o, 1);
    for (int k = 1; k <= TO; k++) begin
      tick();
      instr_req_i = 0;
      chk("t4_wait_rvalid", instr_rvalid_o, 0);
      chk("t4_wait_timeout", timeout_o, 0);
    end
    tick();
    chk("t4_rvalid", instr_rvalid_o, 1);
    chk("t4_rdata_zero", instr_rdata_o, 0);
    chk("t4_timeout", timeout_o, 1);
    data_req_i = 1; data_addr_i = 32'h0220_0020; #1;
    chk("t4_next_gnt", data_gnt_o, 1);
    tick(); data_req_i = 0; flash_done_i = 1; flash_rdata_i = 32'h3333_3333;
    tick(); flash_done_i = 0;
    chk("t4_next_rdata", data_rdata_o, 32'h3333_3333);
    chk("t4_sticky", timeout_o, 1);

    // Reset in the third BUSY cycle.
    tick(); data_req_i = 1; data_addr_i = 32'h0220_0040;
    tick(); data_req_i = 0;
    tick();
    tick(); rst_ni = 0; #1;
    chk("t5_strobe", flash_strobe_o, 0);
    chk("t5_addr", flash_addr_o, 0);
    chk("t5_timeout", timeout_o, 0);
    chk("t5_rvalid", data_rvalid_o, 0);
    tick(); tick(); rst_ni = 1;
    tick(); flash_done_i = 1; flash_rdata_i = 32'h4444_4444;
    tick(); flash_done_i = 0;
    chk("t5_late_done", {30'b0, instr_rvalid_o, data_rvalid_o}, 0);

    // Unaligned address.
    tick(); data_req_i = 1; data_addr_i = 32'h0220_0013;
    tick(); data_req_i = 0;
    chk("t6_addr", flash_addr_o, 24'h200010);
    tick(); tick(); flash_done_i = 1; flash_rdata_i = 32'h6666_6666;
    tick(); flash_done_i = 0;
    chk("t6_rdata", data_rdata_o, 32'h6666_6666);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst_ni = ($urandom % 400) != 0;
      flash_initialized_i = ($urandom % 20) != 0;
      flash_done_i = ($urandom % 5) == 0;
      flash_rdata_i = $urandom;
      if (instr_req_i && !gi) instr_req_i = 1;
      else if (!instr_req_i && ($urandom % 3 == 0)) begin
        instr_req_i = 1; instr_addr_i = {8'h02, 24'($urandom)};
      end else instr_req_i = 0;
      if (data_req_i && !gd) data_req_i = 1;
      else if (!data_req_i && ($urandom % 3 == 0)) begin
        data_req_i = 1; data_addr_i = {8'h02, 24'($urandom)};
      end else data_req_i = 0;
      #1;
      gi = instr_gnt_o; gd = data_gnt_o;
    end
    tick(); rst_ni = 1; data_req_i = 0; instr_req_i = 0; flash_done_i = 0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
